// File: rtl/voice_allocator_pkg.sv
// Shared audio package for the voice allocator slice.
// Holds the allocator state and action enums, the default event field width,
// and the default gate-low hold time derived from the system and sample clocks.
package voice_allocator_pkg;

  localparam int unsigned NOTE_W_DEF      = 7;
  localparam int unsigned NVOICES_DEF     = 4;
  localparam int unsigned SYS_CLK_FREQ    = 32_000_000;
  localparam int unsigned SAMPLE_CLK_FREQ = 31_250;
  // One full sample period, so the envelope always sees the gate low.
  localparam int unsigned RETRIG_CYCLES_DEF = SYS_CLK_FREQ / SAMPLE_CLK_FREQ;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY,
    RETRIG
  } state_t;

  // Action chosen in APPLY once the scan has gathered its candidates.
  typedef enum logic [2:0] {
    K_NONE,
    K_OFF,
    K_ALLOC,
    K_RETRIG,
    K_STEAL
  } kind_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the MIDI/register front end and the allocator.
//   ev_valid : event present (master -> slave)
//   ev_ready : allocator can accept an event (slave -> master)
//   ev_on    : 1 = note-on, 0 = note-off
//   ev_note  : note number
interface voice_allocator_if #(
  parameter int unsigned NOTE_W = voice_allocator_pkg::NOTE_W_DEF
);
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_lru.sv
// voice_lru: least-recently-used rank file for the voice allocator.
// rank[v] = 0 is the most recently allocated voice, NVOICES-1 the oldest.
//   clk, rst   : clock, async active-high reset (rank[v] = v)
//   touch      : mark touch_idx as most recent this cycle
//   touch_idx  : voice being allocated
//   rd_idx     : voice whose rank is read
//   rd_rank    : combinational rank of rd_idx
module voice_lru import voice_allocator_pkg::*; #(
  parameter int unsigned NVOICES = NVOICES_DEF,
  parameter int unsigned IW      = $clog2(NVOICES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch,
  input  logic [IW-1:0] touch_idx,
  input  logic [IW-1:0] rd_idx,
  output logic [IW-1:0] rd_rank
);

  logic [IW-1:0] rank [NVOICES];

  assign rd_rank = rank[rd_idx];

  // Voices younger than the touched one age by one; the permutation is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < NVOICES; v++) rank[v] <= IW'(v);
    end else if (touch) begin
      for (int unsigned v = 0; v < NVOICES; v++) begin
        if (IW'(v) == touch_idx)
          rank[v] <= '0;
        else if (rank[v] < rank[touch_idx])
          rank[v] <= rank[v] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator feeding NVOICES envelope generators.
// Note-on priority: retrigger same note, free voice, releasing voice, LRU steal.
//   clk, rst     : clock, async active-high reset
//   ev           : note event handshake (slave side)
//   voice_active : per-voice envelope volume != 0, used as sampled during scan
//   gate         : per-voice envelope gate
//   voice_note   : per-voice note, voice v at [v*NOTE_W +: NOTE_W]
//   steal        : one-cycle pulse when a gated voice is stolen
module voice_allocator import voice_allocator_pkg::*; #(
  parameter int unsigned NVOICES       = NVOICES_DEF,
  parameter int unsigned NOTE_W        = NOTE_W_DEF,
  parameter int unsigned RETRIG_CYCLES = RETRIG_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  voice_allocator_if.slave          ev,
  input  logic [NVOICES-1:0]        voice_active,
  output logic [NVOICES-1:0]        gate,
  output logic [NVOICES*NOTE_W-1:0] voice_note,
  output logic                      steal
);

  localparam int unsigned IW = $clog2(NVOICES);
  localparam int unsigned CW = $clog2(RETRIG_CYCLES + 1);
  localparam logic [IW-1:0] LAST  = IW'(NVOICES - 1);
  localparam logic [CW-1:0] CLAST = CW'(RETRIG_CYCLES - 1);

  state_t state, state_nx;
  kind_t  kind;

  logic [NVOICES-1:0][NOTE_W-1:0] notes;
  logic [IW-1:0]     idx, sel_v, tgt;
  logic [CW-1:0]     cnt;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic              match_ok, free_ok, rel_ok;
  logic [IW-1:0]     match_idx, free_idx, rel_idx, rel_rank, old_idx, old_rank;
  logic [IW-1:0]     rd_rank;
  logic              touch;

  assign voice_note  = notes;
  assign ev.ev_ready = (state == IDLE);

  voice_lru #(.NVOICES(NVOICES), .IW(IW)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_idx (sel_v),
    .rd_idx    (idx),
    .rd_rank   (rd_rank)
  );

  always_comb begin
    kind  = K_NONE;
    sel_v = old_idx;
    if (!on_q) begin
      if (match_ok) begin
        kind  = K_OFF;
        sel_v = match_idx;
      end
    end else if (match_ok) begin
      kind  = K_RETRIG;
      sel_v = match_idx;
    end else if (free_ok) begin
      kind  = K_ALLOC;
      sel_v = free_idx;
    end else if (rel_ok) begin
      kind  = K_ALLOC;
      sel_v = rel_idx;
    end else begin
      kind  = K_STEAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    touch    = 1'b0;
    case (state)
      // ev_ready is high throughout IDLE, so ev_valid alone is the handshake.
      IDLE:   if (ev.ev_valid) state_nx = SCAN;
      SCAN:   if (idx == LAST) state_nx = APPLY;
      APPLY: begin
        touch    = on_q;
        state_nx = (kind == K_RETRIG || kind == K_STEAL) ? RETRIG : IDLE;
      end
      RETRIG: if (cnt == CLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate      <= '0;
      notes     <= '0;
      steal     <= 1'b0;
      idx       <= '0;
      tgt       <= '0;
      cnt       <= '0;
      on_q      <= 1'b0;
      note_q    <= '0;
      match_ok  <= 1'b0;
      free_ok   <= 1'b0;
      rel_ok    <= 1'b0;
      match_idx <= '0;
      free_idx  <= '0;
      rel_idx   <= '0;
      rel_rank  <= '0;
      old_idx   <= '0;
      old_rank  <= '0;
    end else begin
      steal <= 1'b0;
      case (state)
        IDLE: if (ev.ev_valid) begin
          on_q     <= ev.ev_on;
          note_q   <= ev.ev_note;
          idx      <= '0;
          match_ok <= 1'b0;
          free_ok  <= 1'b0;
          rel_ok   <= 1'b0;
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (gate[idx] && notes[idx] == note_q) begin
            match_ok  <= 1'b1;
            match_idx <= idx;
          end
          if (!gate[idx] && !voice_active[idx] && !free_ok) begin
            free_ok  <= 1'b1;
            free_idx <= idx;
          end
          if (!gate[idx] && voice_active[idx] && (!rel_ok || rd_rank > rel_rank)) begin
            rel_ok   <= 1'b1;
            rel_idx  <= idx;
            rel_rank <= rd_rank;
          end
          if (idx == '0 || rd_rank > old_rank) begin
            old_idx  <= idx;
            old_rank <= rd_rank;
          end
        end
        APPLY: begin
          cnt <= '0;
          tgt <= sel_v;
          case (kind)
            K_OFF, K_RETRIG: gate[sel_v] <= 1'b0;
            K_ALLOC: begin
              gate[sel_v]  <= 1'b1;
              notes[sel_v] <= note_q;
            end
            K_STEAL: begin
              gate[sel_v]  <= 1'b0;
              notes[sel_v] <= note_q;
              steal        <= 1'b1;
            end
            default: ;
          endcase
        end
        RETRIG: begin
          cnt <= cnt + 1'b1;
          if (cnt == CLAST) gate[tgt] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed scenarios plus random note traffic,
// checked by a scoreboard against a list-based LRU reference model.
module tb_voice_allocator;

  localparam int unsigned N  = 4;
  localparam int unsigned NW = 7;
  localparam int unsigned R  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    voice_active = '0;
  logic [N-1:0]    gate;
  logic [N*NW-1:0] voice_note;
  logic            steal;

  voice_allocator_if #(.NOTE_W(NW)) ev_if ();

  voice_allocator #(.NVOICES(N), .NOTE_W(NW), .RETRIG_CYCLES(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .ev           (ev_if),
    .voice_active (voice_active),
    .gate         (gate),
    .voice_note   (voice_note),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    gate_apply;
    logic [N-1:0]    gate_final;
    logic [N*NW-1:0] notes_final;
    int              steals;
    int              lat;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: gate/note per voice, lru[0] most recent, lru[$] oldest.
  bit mg[N];
  int mn[N];
  int lru[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    lru.delete();
    for (int i = 0; i < N; i++) begin
      mg[i] = 1'b0;
      mn[i] = 0;
      lru.push_back(i);
    end
  endfunction

  function automatic logic [N-1:0] pack_g();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = mg[i];
    return g;
  endfunction

  function automatic logic [N*NW-1:0] pack_n();
    logic [N*NW-1:0] n;
    for (int i = 0; i < N; i++) n[i*NW +: NW] = NW'(mn[i]);
    return n;
  endfunction

  function automatic exp_t model(bit on, int note, logic [N-1:0] act);
    exp_t e;
    int   m = -1;
    int   v = -1;
    int   pos = 0;
    bit   retrig = 1'b0;
    e.steals = 0;
    e.lat    = N + 1;
    for (int i = 0; i < N; i++) if (mg[i] && mn[i] == note) m = i;
    if (!on) begin
      if (m >= 0) mg[m] = 1'b0;
      e.gate_apply = pack_g();
    end else begin
      if (m >= 0) begin
        v = m;
        retrig = 1'b1;
      end
      for (int i = 0; i < N && v < 0; i++) if (!mg[i] && !act[i]) v = i;
      for (int k = N - 1; k >= 0 && v < 0; k--) if (!mg[lru[k]] && act[lru[k]]) v = lru[k];
      if (v < 0) begin
        v = lru[N-1];
        retrig = 1'b1;
        e.steals = 1;
      end
      mn[v] = note;
      if (retrig) begin
        mg[v] = 1'b0;
        e.gate_apply = pack_g();
        mg[v] = 1'b1;
        e.lat = N + 1 + R;
      end else begin
        mg[v] = 1'b1;
        e.gate_apply = pack_g();
      end
      for (int k = 0; k < N; k++) if (lru[k] == v) pos = k;
      lru.delete(pos);
      lru.push_front(v);
    end
    e.gate_final  = pack_g();
    e.notes_final = pack_n();
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops an expectation at each accepted event, checks the gate at
  // the apply edge, and the final state, latency and steal count at completion.
  exp_t cur;
  bit   busy = 1'b0;
  int   acc = 0;
  int   st = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (steal) st++;
        if (cyc - acc == N + 1) chk("apply_gate", 64'(gate), 64'(cur.gate_apply));
        if (ev_if.ev_ready) begin
          chk("latency", 64'(cyc - acc), 64'(cur.lat));
          chk("final_gate", 64'(gate), 64'(cur.gate_final));
          chk("final_notes", 64'(voice_note), 64'(cur.notes_final));
          chk("steal_pulses", 64'(st), 64'(cur.steals));
          busy = 1'b0;
        end else if (cyc - acc > cur.lat + 8) begin
          errors++;
          $display("FAIL completion_timeout actual=busy required=ready_by_%0d", cur.lat);
          busy = 1'b0;
        end
      end
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_accept actual=accepted required=no_event");
        end else begin
          cur  = expq.pop_front();
          acc  = cyc + 1;
          st   = 0;
          busy = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    forever begin
      @(negedge clk);
      if (ev_if.ev_ready) break;
      if (++k > 4 * R + 100) begin
        errors++;
        $display("FAIL idle_wait actual=busy required=ready");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(bit on, int note, logic [N-1:0] act);
    int k = 0;
    if (act !== voice_active) begin
      wait_idle();
      voice_active = act;
    end
    expq.push_back(model(on, note, act));
    ev_if.ev_on    = on;
    ev_if.ev_note  = NW'(note);
    ev_if.ev_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ev_if.ev_ready) break;
      if (++k > 4 * R + 100) begin
        errors++;
        $display("FAIL accept_wait actual=not_ready required=ready");
        break;
      end
    end
    @(posedge clk); #1;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'($urandom);
    ev_if.ev_note  = NW'($urandom);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_gate"}, 64'(gate), 64'(0));
    chk({tag, "_notes"}, 64'(voice_note), 64'(0));
    chk({tag, "_ready"}, 64'(ev_if.ev_ready), 64'(1));
    chk({tag, "_steal"}, 64'(steal), 64'(0));
    ev_if.ev_valid = 1'b0;
    expq.delete();
    model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] a;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;
    model_reset();
    rst = 1'b1;
    #3;
    chk("por_gate", 64'(gate), 64'(0));
    chk("por_notes", 64'(voice_note), 64'(0));
    chk("por_ready", 64'(ev_if.ev_ready), 64'(1));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill all voices, then release one and reuse it as the releasing voice.
    send(1, 60, 4'b0000);
    send(1, 62, 4'b0000);
    send(1, 64, 4'b0000);
    send(1, 65, 4'b0000);
    send(0, 62, 4'b1111);
    send(1, 67, 4'b1111);
    wait_idle();

    // Steal the oldest twice, retrigger a held note, ignore an unheld note-off.
    do_reset("rst_a");
    send(1, 60, 4'b0000);
    send(1, 62, 4'b0000);
    send(1, 64, 4'b0000);
    send(1, 65, 4'b0000);
    send(1, 70, 4'b0000);
    send(1, 72, 4'b0000);
    send(1, 64, 4'b0000);
    send(0, 50, 4'b0000);
    wait_idle();

    // Reset while holding a stolen voice low.
    send(1, 80, 4'b0000);
    repeat (N + 4) @(posedge clk);
    #1;
    do_reset("rst_retrig");
    send(1, 60, 4'b0000);
    wait_idle();

    // Reset partway through a scan.
    send(1, 61, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst_scan");
    send(1, 60, 4'b0000);
    wait_idle();

    for (int i = 0; i < 150; i++) begin
      a = voice_active;
      if ($urandom_range(0, 3) == 0) a = N'($urandom);
      send($urandom_range(0, 2) != 0, 48 + int'($urandom_range(0, 9)), a);
    end
    wait_idle();
    @(posedge clk); #1;
    chk("drain_queue", 64'(expq.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
